audio_sample_scheduler: RTL and testbench
=========================================

AUDIO_SAMPLE_SCHEDULER -- requirements
Module: audio_sample_scheduler

Interface
REQ-001 Parameter CLK_DIV, default 1042, clk cycles per sample period (50 MHz / 1042 = approx. 48 kHz); legal range 8..65535.
REQ-002 clk  in  1  system clock, 50 MHz.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 src0_valid  in  1  source 0 has a sample available.
REQ-005 src0_data  in  16  source 0 sample, two's complement.
REQ-006 src0_ready  out  1  one-cycle pulse; source 0 sample consumed this cycle.
REQ-007 src1_valid / src1_data / src1_ready  in 1 / in 16 / out 1  source 1, same semantics as source 0.
REQ-008 mute  in  1  forces zero output samples.
REQ-009 audio_out_allowed  in  1  codec output FIFO has space.
REQ-010 left_out  out  32  left sample to codec.
REQ-011 right_out  out  32  right sample to codec.
REQ-012 write_audio_out  out  1  one-cycle write strobe to codec.
REQ-013 last_grant  out  1  index of the last source served.
REQ-014 underrun_cnt  out  16  count of sample periods with no valid source.
REQ-015 overrun  out  1  sticky flag: a tick arrived while the FSM was not in IDLE.

Function
REQ-016 The tick counter SHALL count 0..CLK_DIV-1 and wrap to 0; tick SHALL be high for exactly the one cycle in which the count equals CLK_DIV-1.
REQ-017 The FSM SHALL have three states, IDLE, ARB and WAIT_ALLOWED, with transitions: IDLE->ARB on tick; ARB->WAIT_ALLOWED unconditionally; WAIT_ALLOWED->IDLE in the cycle audio_out_allowed=1.
REQ-018 Arbitration in ARB SHALL be round-robin: if both sources are valid, the source not equal to last_grant wins; if exactly one is valid, that source wins.
REQ-019 In ARB, the winning srcN_ready SHALL pulse for exactly one cycle; the winner's data SHALL be latched; last_grant SHALL be set to the winner.
REQ-020 If no source is valid in ARB, the latched sample SHALL be 0, no ready SHALL pulse, last_grant SHALL hold, and underrun_cnt SHALL increment, saturating at 16'hFFFF.
REQ-021 Formatting: left_out = right_out = {sample, 16'h0000}; if mute=1 in ARB, the latched sample SHALL be 0, but the winner SHALL still be consumed.
REQ-022 left_out and right_out SHALL update only on the latch edge and otherwise hold.
REQ-023 write_audio_out SHALL be asserted in WAIT_ALLOWED only in the cycle audio_out_allowed=1, for exactly one cycle per sample period.
REQ-024 Latency: with audio_out_allowed held at 1, write_audio_out SHALL occur 2 cycles after the tick cycle.
REQ-025 A tick arriving in ARB or WAIT_ALLOWED SHALL be dropped and SHALL set overrun=1; overrun SHALL clear only on reset.
REQ-026 src0_ready and src1_ready SHALL never be high in the same cycle, and neither SHALL be high outside ARB.

Reset
REQ-027 While resetn=0 at a clk edge, the block SHALL set:
- tick counter = 0; FSM state = IDLE
- left_out = right_out = 0
- write_audio_out = 0; src0_ready = src1_ready = 0
- last_grant = 1, so source 0 wins the first contention
- underrun_cnt = 0; overrun = 0
REQ-028 Reset asserted mid-period or in WAIT_ALLOWED SHALL abandon the pending write without a strobe; after release, the first tick SHALL occur CLK_DIV cycles later.

Structure
REQ-029 The FSM state encoding and the CLK_DIV default SHALL reside in the shared package audio_pkg.
REQ-030 The tick counter SHALL be a sub-module named sample_tick_gen (ports: clk, resetn, tick), parameterised by CLK_DIV.

Verification
REQ-031 CLK_DIV=8, both sources always valid, allowed=1 -> grants alternate 0,1,0,1; write_audio_out every 8 cycles; first write at cycle 10 after reset release.
REQ-032 Only src1 valid with data 16'h8001 -> left_out = right_out = 32'h80010000; src1_ready pulses once per period; last_grant = 1.
REQ-033 No source valid for 3 periods -> three writes of 32'h0; underrun_cnt = 3.
REQ-034 allowed=0 for 20 cycles with CLK_DIV=8 -> no strobe; overrun = 1; one write when allowed returns to 1.
REQ-035 mute=1 with src0 data 16'h1234 valid -> src0_ready pulses; left_out = 32'h0.
REQ-036 resetn=0 asserted in WAIT_ALLOWED -> no strobe; all outputs at reset values; underrun_cnt = 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample scheduler: FSM encoding, default
// sample-period divider and the round-robin pick.
package audio_pkg;

    localparam int unsigned AUDIO_CLK_DIV = 1042;
    localparam logic [15:0] UNDERRUN_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ARB          = 2'd1,
        ST_WAIT_ALLOWED = 2'd2
    } sched_state_t;

    // Returns the winning source index; only meaningful when v0 | v1.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? ~last : v1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period tick: counts 0..CLK_DIV-1 and flags the last count.
module sample_tick_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = AUDIO_CLK_DIV
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    logic [15:0] r_cnt;
    logic        w_wrap;

    assign w_wrap = (r_cnt == 16'(CLK_DIV - 1));
    assign tick   = w_wrap;

    always_ff @(posedge clk) begin
        if (!resetn)     r_cnt <= '0;
        else if (w_wrap) r_cnt <= '0;
        else             r_cnt <= r_cnt + 16'd1;
    end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Pulls one sample per period from two round-robin sources and hands it to
// the codec as a stereo pair once the codec FIFO has room.
module audio_sample_scheduler
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = AUDIO_CLK_DIV
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        src0_valid,
    input  logic [15:0] src0_data,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [15:0] src1_data,
    output logic        src1_ready,
    input  logic        mute,
    input  logic        audio_out_allowed,
    output logic [31:0] left_out,
    output logic [31:0] right_out,
    output logic        write_audio_out,
    output logic        last_grant,
    output logic [15:0] underrun_cnt,
    output logic        overrun
);

    sched_state_t r_state, w_next;
    logic         w_tick, w_any, w_win;
    logic [15:0]  w_sample;
    logic [31:0]  r_out;
    logic         r_last, r_ovr;
    logic [15:0]  r_und;

    sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (w_tick)
    );

    assign w_any    = src0_valid | src1_valid;
    assign w_win    = rr_pick(src0_valid, src1_valid, r_last);
    assign w_sample = (mute || !w_any) ? 16'h0000 : (w_win ? src1_data : src0_data);

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        src0_ready      = 1'b0;
        src1_ready      = 1'b0;
        write_audio_out = 1'b0;
        case (r_state)
            ST_IDLE: if (w_tick) w_next = ST_ARB;
            ST_ARB: begin
                w_next = ST_WAIT_ALLOWED;
                if (w_any) begin
                    src0_ready = ~w_win;
                    src1_ready = w_win;
                end
            end
            ST_WAIT_ALLOWED: if (audio_out_allowed) begin
                write_audio_out = 1'b1;
                w_next          = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Muted or starved periods still latch, so the codec always gets a sample.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out  <= '0;
            r_last <= 1'b1;
            r_und  <= '0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_tick && r_state != ST_IDLE) r_ovr <= 1'b1;
            if (r_state == ST_ARB) begin
                r_out <= {w_sample, 16'h0000};
                if (w_any)                      r_last <= w_win;
                else if (r_und != UNDERRUN_MAX) r_und  <= r_und + 16'd1;
            end
        end
    end

    assign left_out     = r_out;
    assign right_out    = r_out;
    assign last_grant   = r_last;
    assign underrun_cnt = r_und;
    assign overrun      = r_ovr;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Randomized and directed check of audio_sample_scheduler against a
// cycle-level behavioural model, with literal expectations for key scenarios.
module tb_audio_sample_scheduler;

    localparam int CD = 8;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        src0_valid = 0, src1_valid = 0, mute = 0, audio_out_allowed = 1;
    logic [15:0] src0_data = 0, src1_data = 0;
    logic        src0_ready, src1_ready, write_audio_out, last_grant, overrun;
    logic [31:0] left_out, right_out;
    logic [15:0] underrun_cnt;

    always #5 clk = ~clk;

    audio_sample_scheduler #(.CLK_DIV(CD)) dut (
        .clk(clk), .resetn(resetn),
        .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
        .mute(mute), .audio_out_allowed(audio_out_allowed),
        .left_out(left_out), .right_out(right_out), .write_audio_out(write_audio_out),
        .last_grant(last_grant), .underrun_cnt(underrun_cnt), .overrun(overrun)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position in the sample period, whether this cycle arbitrates,
    // whether a sample is waiting for the codec, plus the visible state.
    int          m_k = 0, m_und = 0;
    bit          m_arb = 0, m_wait = 0, m_last = 1, m_ovr = 0;
    logic [31:0] m_out = 0;

    int cyc = 0, n_wr = 0, n_r0 = 0, n_r1 = 0, first_wr = -1;
    int gq[$];

    always @(negedge clk) begin
        bit          e_r0, e_r1, w, win, any, tk, idle;
        logic [15:0] d;
        e_r0 = 0; e_r1 = 0; win = 0;
        any  = src0_valid || src1_valid;
        if (m_arb && any) begin
            win  = (src0_valid && src1_valid) ? !m_last : src1_valid;
            e_r0 = !win;
            e_r1 = win;
        end
        w = m_wait && audio_out_allowed;

        chk("src0_ready", src0_ready, e_r0);
        chk("src1_ready", src1_ready, e_r1);
        chk("write", write_audio_out, w);
        chk("left_out", left_out, m_out);
        chk("right_out", right_out, m_out);
        chk("last_grant", last_grant, m_last);
        chk("underrun_cnt", underrun_cnt, m_und[15:0]);
        chk("overrun", overrun, m_ovr);

        if (resetn) cyc++;
        if (write_audio_out) begin n_wr++; if (first_wr < 0) first_wr = cyc; end
        if (src0_ready) begin n_r0++; gq.push_back(0); end
        if (src1_ready) begin n_r1++; gq.push_back(1); end

        if (!resetn) begin
            m_k = 0; m_arb = 0; m_wait = 0; m_last = 1; m_ovr = 0; m_out = 0; m_und = 0;
        end else begin
            tk   = (m_k == CD - 1);
            idle = !m_arb && !m_wait;
            if (m_arb) begin
                if (any) begin
                    m_last = win;
                    d = win ? src1_data : src0_data;
                end else begin
                    d = 16'h0;
                    if (m_und < 65535) m_und++;
                end
                if (mute) d = 16'h0;
                m_out  = {d, 16'h0000};
                m_arb  = 0;
                m_wait = 1;
            end else if (w) begin
                m_wait = 0;
            end
            if (tk) begin
                if (idle) m_arb = 1;
                else      m_ovr = 1;
            end
            m_k = (m_k + 1) % CD;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr();
        cyc = 0; n_wr = 0; n_r0 = 0; n_r1 = 0; first_wr = -1; gq.delete();
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        step(2);
        clr();
        resetn = 1'b1;
    endtask

    initial begin
        int g0, g1, g2, g3;
        step(1);

        // both valid, codec always ready: alternating grants, writes every CD cycles
        src0_valid = 1; src1_valid = 1; src0_data = 16'h1111; src1_data = 16'h2222;
        audio_out_allowed = 1; mute = 0;
        reset_dut();
        step(34);
        chk("first_write_cycle", first_wr, 10);
        chk("writes_in_4_periods", n_wr, 4);
        chk("grant_count", gq.size(), 4);
        g0 = gq.size() > 0 ? gq[0] : -1; g1 = gq.size() > 1 ? gq[1] : -1;
        g2 = gq.size() > 2 ? gq[2] : -1; g3 = gq.size() > 3 ? gq[3] : -1;
        chk("grant0", g0, 0); chk("grant1", g1, 1); chk("grant2", g2, 0); chk("grant3", g3, 1);

        // only src1 valid
        src0_valid = 0; src1_valid = 1; src1_data = 16'h8001;
        reset_dut();
        step(26);
        chk("src1_only_left", left_out, 32'h80010000);
        chk("src1_only_right", right_out, 32'h80010000);
        chk("src1_ready_pulses", n_r1, 3);
        chk("src0_ready_none", n_r0, 0);
        chk("src1_only_last_grant", last_grant, 1);

        // starvation for 3 periods
        src0_valid = 0; src1_valid = 0;
        reset_dut();
        step(26);
        chk("underrun_writes", n_wr, 3);
        chk("underrun_left", left_out, 32'h0);
        chk("underrun_cnt_3", underrun_cnt, 3);

        // codec stalled for 20 cycles
        src0_valid = 1; src0_data = 16'h0abc; audio_out_allowed = 0;
        reset_dut();
        step(20);
        chk("stall_no_write", n_wr, 0);
        chk("stall_overrun", overrun, 1);
        audio_out_allowed = 1;
        step(3);
        chk("stall_one_write", n_wr, 1);

        // muted
        src0_valid = 1; src1_valid = 0; src0_data = 16'h1234; mute = 1;
        reset_dut();
        step(10);
        chk("mute_src0_ready", n_r0, 1);
        chk("mute_write", n_wr, 1);
        chk("mute_left", left_out, 32'h0);
        mute = 0;

        // reset while waiting for the codec
        src0_valid = 0; audio_out_allowed = 0;
        reset_dut();
        step(12);
        chk("pre_reset_underrun", underrun_cnt, 1);
        resetn = 1'b0;
        step(1);
        audio_out_allowed = 1;
        step(2);
        chk("rst_write", write_audio_out, 0);
        chk("rst_left", left_out, 0);
        chk("rst_last_grant", last_grant, 1);
        chk("rst_underrun", underrun_cnt, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_no_strobe", n_wr, 0);
        clr();
        resetn = 1'b1;
        step(9);
        chk("rst_no_write_before_first_tick", n_wr, 0);

        // random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            src0_valid        = ($urandom_range(0, 3) != 0);
            src1_valid        = ($urandom_range(0, 3) != 0);
            src0_data         = 16'($urandom);
            src1_data         = 16'($urandom);
            mute              = ($urandom_range(0, 9) == 0);
            audio_out_allowed = ($urandom_range(0, 3) != 0);
            resetn            = ($urandom_range(0, 199) != 0);
            step(1);
        end
        resetn = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
